md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL provide one clock and a synchronous active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 SHALL have port: start  input  1  request valid in Execute; sampled only when accepting (IDLE or DONE).
REQ-003 SHALL have port: funct3  input  3  RV32M op. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-004 SHALL have port: SrcAE  input  32  rs1 operand.
REQ-005 SHALL have port: SrcBE  input  32  rs2 operand.
REQ-006 SHALL have port: RdE  input  5  destination register tag.
REQ-007 SHALL have port: FlushE  input  1  kill the in-flight operation.
REQ-008 SHALL have port: busy  output  1  operation in progress; the hazard unit stalls F/D/E on it.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: ResultMD  output  32  result.
REQ-011 SHALL have port: RdMD  output  5  destination tag of the result.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL capture funct3, operands and RdE when start is accepted in IDLE or DONE.
REQ-014 Start with funct3[2]=0 SHALL go to MUL.
- MUL computes a 64-bit product, signed/unsigned per op, in one cycle.
- Next state is DONE.
- Result is the low 32 bits for MUL and the high 32 bits otherwise.
REQ-015 Start with funct3[2]=1 and a normal divisor SHALL go to DIV.
- Unsigned restoring division on operand magnitudes.
- Exactly 32 iterations; 5-bit counter 0..31.
- Goes to DONE after iteration 31.
- Signs applied on exit: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
REQ-016 Division by zero SHALL take the MUL-length path (one cycle, then DONE).
- Quotient = 0xFFFFFFFF.
- Remainder = SrcAE.
REQ-017 Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF) SHALL take the MUL-length path.
- Quotient = 0x80000000.
- Remainder = 0.
REQ-018 Latency SHALL be fixed, with start accepted at edge T.
- MUL and special divides: done high in cycle T+2.
- Normal DIV/REM: done high in cycle T+33.
REQ-019 busy SHALL be 1 exactly while the state is MUL or DIV, and 0 in IDLE and DONE.
REQ-020 done SHALL be 1 only in DONE, for exactly one cycle per accepted op.
REQ-021 DONE SHALL go to IDLE, or directly to MUL/DIV if start is high (back-to-back, no bubble).
REQ-022 Start while in MUL or DIV SHALL be ignored.
- Captured operands and counter stay unchanged.
REQ-023 ResultMD and RdMD SHALL update only on entry to DONE and hold until the next DONE.
REQ-024 FlushE SHALL have priority over start; flush in any state causes the next state to be IDLE.
- No done pulse.
- ResultMD/RdMD unchanged.
- A flush in DONE does not suppress that cycle's done.
- Start in the flush cycle is not accepted.
REQ-025 Internal arithmetic SHALL use 33-bit remainder and 64-bit product registers; no overflow flags are exposed.

Reset
REQ-026 reset SHALL take priority over FlushE and start.
REQ-027 On reset the block SHALL enter IDLE, with:
- busy=0 and done=0.
- ResultMD=0 and RdMD=0.
- Counter and operand registers zero.
REQ-028 Reset mid-operation SHALL abort the operation with no done pulse, leaving the outputs as in REQ-027.

Verification
REQ-029 MULH -5 x 3 (0xFFFFFFFB, 0x00000003, Rd=7) -> done at T+2, ResultMD=0xFFFFFFFF, RdMD=7; MUL same operands -> 0xFFFFFFF1.
REQ-030 DIV -7 / 2 -> done at T+33, ResultMD=0xFFFFFFFD; REM same -> 0xFFFFFFFF; busy high in cycles T+1..T+32.
REQ-031 DIVU 5 / 0 -> done at T+2, 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000 at T+2.
REQ-032 FlushE at T+10 of a DIV -> IDLE at T+11, no done, ResultMD keeps its previous value; start asserted with FlushE is ignored.
REQ-033 Back-to-back: start held with MULHU 0xFFFFFFFF x 0xFFFFFFFF then DIVU 100/7 -> done at T+2 (0xFFFFFFFE), next op accepted in the same DONE cycle, done at T+35 (0x0000000E).
REQ-034 reset asserted at T+5 of a DIV -> next cycle busy=0, done=0, ResultMD=0, RdMD=0; no done afterwards.

Source files
------------

// File: rtl/md_unit.sv
// RV32M multiply/divide unit for the Execute stage: MUL and special divides take one busy cycle, normal DIV/REM take 32.
// Latency: start accepted at edge T gives done in cycle T+2 (MUL, divide-by-zero, signed overflow) or T+33 (DIV/REM).
// Backpressure: busy is high while computing so the hazard unit stalls F/D/E; start is ignored unless IDLE or DONE.
module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic [4:0]  RdE,
    input  logic        FlushE,
    output logic        busy,
    output logic        done,
    output logic [31:0] ResultMD,
    output logic [4:0]  RdMD
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nx;

    logic [2:0]  f3_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  rd_q;
    logic [4:0]  cnt;
    logic [63:0] prod;
    logic [32:0] rem;
    logic [31:0] quo;
    logic        dz_q;
    logic        ovf_q;

    // Acceptance and classification of the incoming request
    logic        accepting;
    logic        accept;
    logic        in_signed_div;
    logic        in_div_zero;
    logic        in_ovf;
    logic        in_go_div;
    logic [31:0] in_a_mag;

    assign accepting     = (state == IDLE) || (state == DONE);
    assign accept        = accepting && start && !FlushE;
    assign in_signed_div = ~funct3[0];
    assign in_div_zero   = (SrcBE == 32'd0);
    assign in_ovf        = in_signed_div && (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
    assign in_go_div     = funct3[2] && !in_div_zero && !in_ovf;
    assign in_a_mag      = (in_signed_div && SrcAE[31]) ? (32'd0 - SrcAE) : SrcAE;

    // Multiplier operands sign-extended to 64 bits; low 64 bits of the product are exact
    logic        ma_sign;
    logic        mb_sign;
    logic [63:0] ma64;
    logic [63:0] mb64;
    logic [63:0] prod_in;

    assign ma_sign = (funct3[1:0] != 2'b11) & SrcAE[31];
    assign mb_sign = ~funct3[1] & SrcBE[31];
    assign ma64    = {{32{ma_sign}}, SrcAE};
    assign mb64    = {{32{mb_sign}}, SrcBE};
    assign prod_in = ma64 * mb64;

    // One restoring-division step on the magnitudes
    logic        q_signed;
    logic        is_rem;
    logic [31:0] b_mag;
    logic [33:0] shifted;
    logic [33:0] trial;
    logic [32:0] rem_nx;
    logic [31:0] quo_nx;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] div_res;
    logic [31:0] mul_res;

    assign q_signed = ~f3_q[0];
    assign is_rem   = f3_q[1];
    assign b_mag    = (q_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    assign shifted  = {rem, quo[31]};
    assign trial    = shifted - {2'b00, b_mag};
    assign rem_nx   = trial[33] ? shifted[32:0] : trial[32:0];
    assign quo_nx   = {quo[30:0], ~trial[33]};
    assign neg_q    = q_signed & (a_q[31] ^ b_q[31]);
    assign neg_r    = q_signed & a_q[31];

    // Final signed fix-up, applied on the last iteration's values
    always_comb begin
        div_res = 32'd0;
        if (is_rem)
            div_res = neg_r ? (32'd0 - rem_nx[31:0]) : rem_nx[31:0];
        else
            div_res = neg_q ? (32'd0 - quo_nx) : quo_nx;
    end

    // Short-path result: products plus the two divide special cases
    always_comb begin
        mul_res = 32'd0;
        if (f3_q[2]) begin
            if (dz_q)
                mul_res = is_rem ? a_q : 32'hFFFF_FFFF;
            else if (ovf_q)
                mul_res = is_rem ? 32'd0 : 32'h8000_0000;
        end else if (f3_q[1:0] == 2'b00) begin
            mul_res = prod[31:0];
        end else begin
            mul_res = prod[63:32];
        end
    end

    // Next-state logic; flush beats start and always returns to IDLE
    always_comb begin
        state_nx = state;
        if (FlushE) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start)
                        state_nx = in_go_div ? DIV : MUL;
                    else
                        state_nx = IDLE;
                end
                MUL:     state_nx = DONE;
                DIV:     state_nx = (cnt == 5'd31) ? DONE : DIV;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign busy = (state == MUL) || (state == DIV);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Operand capture on accept, one division step per DIV cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            f3_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            rd_q  <= 5'd0;
            cnt   <= 5'd0;
            prod  <= 64'd0;
            rem   <= 33'd0;
            quo   <= 32'd0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            f3_q  <= funct3;
            a_q   <= SrcAE;
            b_q   <= SrcBE;
            rd_q  <= RdE;
            cnt   <= 5'd0;
            prod  <= prod_in;
            rem   <= 33'd0;
            quo   <= in_a_mag;
            dz_q  <= funct3[2] && in_div_zero;
            ovf_q <= funct3[2] && in_ovf;
        end else if ((state == DIV) && !FlushE) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 5'd1;
        end
    end

    // Result registers load only on the transition into DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            ResultMD <= 32'd0;
            RdMD     <= 5'd0;
        end else if (!FlushE) begin
            if (state == MUL) begin
                ResultMD <= mul_res;
                RdMD     <= rd_q;
            end else if ((state == DIV) && (cnt == 5'd31)) begin
                ResultMD <= div_res;
                RdMD     <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [4:0]  RdE;
    logic        FlushE;
    logic        busy;
    logic        done;
    logic [31:0] ResultMD;
    logic [4:0]  RdMD;

    int n_cmp;
    int n_fail;

    md_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .funct3   (funct3),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .RdE      (RdE),
        .FlushE   (FlushE),
        .busy     (busy),
        .done     (done),
        .ResultMD (ResultMD),
        .RdMD     (RdMD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request before edge T and return 1 time unit after edge T
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        SrcAE  = a;
        SrcBE  = b;
        RdE    = rd;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done=%b required 00", {busy, done});
        end
        n_cmp++;
        if (ResultMD !== 32'd0 || RdMD !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ResultMD=%h RdMD=%0d required 0/0", ResultMD, RdMD);
        end
    endtask

    // Single-busy-cycle ops: products and divide special cases
    task automatic test_short_ops();
        logic [2:0]  t_f3  [8];
        logic [31:0] t_a   [8];
        logic [31:0] t_b   [8];
        logic [4:0]  t_rd  [8];
        logic [31:0] t_exp [8];
        t_f3[0] = 3'b001; t_a[0] = 32'hFFFF_FFFB; t_b[0] = 32'd3;          t_rd[0] = 5'd7;  t_exp[0] = 32'hFFFF_FFFF;
        t_f3[1] = 3'b000; t_a[1] = 32'hFFFF_FFFB; t_b[1] = 32'd3;          t_rd[1] = 5'd7;  t_exp[1] = 32'hFFFF_FFF1;
        t_f3[2] = 3'b010; t_a[2] = 32'hFFFF_FFFF; t_b[2] = 32'hFFFF_FFFF;  t_rd[2] = 5'd9;  t_exp[2] = 32'hFFFF_FFFF;
        t_f3[3] = 3'b011; t_a[3] = 32'h0001_0000; t_b[3] = 32'h0001_0000;  t_rd[3] = 5'd10; t_exp[3] = 32'h0000_0001;
        t_f3[4] = 3'b101; t_a[4] = 32'd5;         t_b[4] = 32'd0;          t_rd[4] = 5'd11; t_exp[4] = 32'hFFFF_FFFF;
        t_f3[5] = 3'b111; t_a[5] = 32'd5;         t_b[5] = 32'd0;          t_rd[5] = 5'd12; t_exp[5] = 32'd5;
        t_f3[6] = 3'b100; t_a[6] = 32'h8000_0000; t_b[6] = 32'hFFFF_FFFF;  t_rd[6] = 5'd13; t_exp[6] = 32'h8000_0000;
        t_f3[7] = 3'b110; t_a[7] = 32'h8000_0000; t_b[7] = 32'hFFFF_FFFF;  t_rd[7] = 5'd14; t_exp[7] = 32'd0;
        for (int i = 0; i < 8; i++) begin
            issue(t_f3[i], t_a[i], t_b[i], t_rd[i]);
            n_cmp++;
            if ({busy, done} !== 2'b10) begin
                n_fail++;
                $display("FAIL short%0d_busy: busy/done=%b required 10", i, {busy, done});
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({busy, done} !== 2'b01 || ResultMD !== t_exp[i] || RdMD !== t_rd[i]) begin
                n_fail++;
                $display("FAIL short%0d_done: busy/done=%b ResultMD=%h RdMD=%0d required 01 %h %0d",
                         i, {busy, done}, ResultMD, RdMD, t_exp[i], t_rd[i]);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({busy, done} !== 2'b00 || ResultMD !== t_exp[i]) begin
                n_fail++;
                $display("FAIL short%0d_idle: busy/done=%b ResultMD=%h required 00 %h",
                         i, {busy, done}, ResultMD, t_exp[i]);
            end
        end
    endtask

    // Normal 32-iteration divides with full busy window check
    task automatic test_div();
        logic [2:0]  t_f3  [4];
        logic [31:0] t_a   [4];
        logic [31:0] t_b   [4];
        logic [31:0] t_exp [4];
        int bad;
        t_f3[0] = 3'b100; t_a[0] = 32'hFFFF_FFF9; t_b[0] = 32'd2;         t_exp[0] = 32'hFFFF_FFFD;
        t_f3[1] = 3'b110; t_a[1] = 32'hFFFF_FFF9; t_b[1] = 32'd2;         t_exp[1] = 32'hFFFF_FFFF;
        t_f3[2] = 3'b100; t_a[2] = 32'd100;       t_b[2] = 32'hFFFF_FFF9; t_exp[2] = 32'hFFFF_FFF2;
        t_f3[3] = 3'b111; t_a[3] = 32'hFFFF_FFFF; t_b[3] = 32'd10;        t_exp[3] = 32'd5;
        for (int i = 0; i < 4; i++) begin
            issue(t_f3[i], t_a[i], t_b[i], 5'd20 + 5'(i));
            bad = 0;
            for (int c = 0; c < 32; c++) begin
                if (c > 0) begin
                    @(posedge clk);
                    #1;
                end
                if ({busy, done} !== 2'b10) bad++;
            end
            n_cmp++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL div%0d_busy_window: %0d of 32 cycles not busy required 0", i, bad);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({busy, done} !== 2'b01 || ResultMD !== t_exp[i] || RdMD !== 5'd20 + 5'(i)) begin
                n_fail++;
                $display("FAIL div%0d_done: busy/done=%b ResultMD=%h RdMD=%0d required 01 %h %0d",
                         i, {busy, done}, ResultMD, RdMD, t_exp[i], 20 + i);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL div%0d_idle: busy/done=%b required 00", i, {busy, done});
            end
        end
    endtask

    // Flush mid-divide with a competing start; outputs must not move
    task automatic test_flush();
        int seen;
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3);
        repeat (9) @(posedge clk);
        #1;
        FlushE = 1'b1;
        start  = 1'b1;
        funct3 = 3'b000;
        SrcAE  = 32'd6;
        SrcBE  = 32'd7;
        RdE    = 5'd30;
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        start  = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_idle: busy/done=%b required 00", {busy, done});
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_no_done: %0d active cycles required 0", seen);
        end
        n_cmp++;
        if (ResultMD !== 32'd5 || RdMD !== 5'd23) begin
            n_fail++;
            $display("FAIL flush_hold: ResultMD=%h RdMD=%0d required 00000005 23", ResultMD, RdMD);
        end
    endtask

    // Start held through a MUL and straight into a DIV from DONE
    task automatic test_back_to_back();
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b011;
        SrcAE  = 32'hFFFF_FFFF;
        SrcBE  = 32'hFFFF_FFFF;
        RdE    = 5'd3;
        @(posedge clk);
        #1;
        funct3 = 3'b101;
        SrcAE  = 32'd100;
        SrcBE  = 32'd7;
        RdE    = 5'd4;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b01 || ResultMD !== 32'hFFFF_FFFE || RdMD !== 5'd3) begin
            n_fail++;
            $display("FAIL b2b_first: busy/done=%b ResultMD=%h RdMD=%0d required 01 fffffffe 3",
                     {busy, done}, ResultMD, RdMD);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_accept: busy/done=%b required 10", {busy, done});
        end
        repeat (32) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b01 || ResultMD !== 32'h0000_000E || RdMD !== 5'd4) begin
            n_fail++;
            $display("FAIL b2b_second: busy/done=%b ResultMD=%h RdMD=%0d required 01 0000000e 4",
                     {busy, done}, ResultMD, RdMD);
        end
        @(posedge clk);
        #1;
    endtask

    // Reset during a divide clears everything and suppresses done
    task automatic test_reset_mid_op();
        int seen;
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd17);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00 || ResultMD !== 32'd0 || RdMD !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy/done=%b ResultMD=%h RdMD=%0d required 00 0 0",
                     {busy, done}, ResultMD, RdMD);
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: %0d active cycles required 0", seen);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        start  = 1'b0;
        funct3 = 3'd0;
        SrcAE  = 32'd0;
        SrcBE  = 32'd0;
        RdE    = 5'd0;
        FlushE = 1'b0;
        test_reset();
        test_short_ops();
        test_div();
        test_flush();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
